// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII decimal-number parser: FSM states,
// the ASCII characters it recognises and the error codes it reports.
package ascii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        OUT  = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational conversion of three BCD digits (0-9 each) to a 10-bit
// unsigned value, using constant shifts and adds only.
module bcd3_to_bin (
    input  logic [3:0] hund,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [9:0] value
);

    logic [9:0] h;
    logic [9:0] t;
    logic [9:0] u;

    assign h = {6'd0, hund};
    assign t = {6'd0, tens};
    assign u = {6'd0, units};

    // 100 = 64 + 32 + 4, 10 = 8 + 2; digits never exceed 9 so 999 fits
    assign value = (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + u;

endmodule

// File: rtl/ascii2bcd.sv
// Parses up to three ASCII decimal digits terminated by TERM_CHAR and
// publishes the number as BCD and binary, with error reporting.
//
// state | meaning
// IDLE  | waiting for the first digit; TERM_CHAR and space ignored
// DIG   | collecting digits, inter-character timeout running
// OUT   | one cycle: num_valid pulse, new number on bcd_*/bin_out
// ERR   | one cycle: num_err pulse, err_code updated
module ascii2bcd
    import ascii_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR      = 8'h0D,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [3:0] bcd_0,
    output logic [3:0] bcd_1,
    output logic [3:0] bcd_2,
    output logic [9:0] bin_out,
    output logic       num_valid,
    output logic       num_err,
    output logic [1:0] err_code,
    output logic [1:0] digit_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [3:0]    w_hund;
    logic [3:0]    w_tens;
    logic [3:0]    w_units;
    logic [TW-1:0] tmo_cnt;
    logic [9:0]    w_bin;
    logic          accept;

    assign accept = char_valid && char_ready;

    bcd3_to_bin u_conv (
        .hund  (w_hund),
        .tens  (w_tens),
        .units (w_units),
        .value (w_bin)
    );

    // Sequencing FSM with all outputs registered; the timeout is a
    // down-counter reloaded on every accepted character in DIG.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            w_hund     <= 4'd0;
            w_tens     <= 4'd0;
            w_units    <= 4'd0;
            digit_cnt  <= 2'd0;
            tmo_cnt    <= '0;
            bcd_0      <= 4'd0;
            bcd_1      <= 4'd0;
            bcd_2      <= 4'd0;
            bin_out    <= 10'd0;
            err_code   <= ERR_NONE;
            num_valid  <= 1'b0;
            num_err    <= 1'b0;
            char_ready <= 1'b1;
        end else begin
            num_valid <= 1'b0;
            num_err   <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (accept) begin
                        if (is_digit(char_in)) begin
                            // low nibble of '0'..'9' is the digit value
                            w_units   <= char_in[3:0];
                            digit_cnt <= 2'd1;
                            tmo_cnt   <= TMO_LOAD;
                            state     <= DIG;
                        end else if (char_in != TERM_CHAR && char_in != ASCII_SPACE) begin
                            err_code   <= ERR_BAD_CHAR;
                            num_err    <= 1'b1;
                            char_ready <= 1'b0;
                            state      <= ERR;
                        end
                    end
                end
                DIG: begin
                    if (accept) begin
                        tmo_cnt <= TMO_LOAD;
                        if (is_digit(char_in)) begin
                            if (digit_cnt == 2'd3) begin
                                err_code   <= ERR_OVERFLOW;
                                num_err    <= 1'b1;
                                char_ready <= 1'b0;
                                state      <= ERR;
                            end else begin
                                w_hund    <= w_tens;
                                w_tens    <= w_units;
                                w_units   <= char_in[3:0];
                                digit_cnt <= digit_cnt + 2'd1;
                            end
                        end else if (char_in == TERM_CHAR) begin
                            bcd_2      <= w_hund;
                            bcd_1      <= w_tens;
                            bcd_0      <= w_units;
                            bin_out    <= w_bin;
                            num_valid  <= 1'b1;
                            char_ready <= 1'b0;
                            state      <= OUT;
                        end else begin
                            err_code   <= ERR_BAD_CHAR;
                            num_err    <= 1'b1;
                            char_ready <= 1'b0;
                            state      <= ERR;
                        end
                    end else if (tmo_cnt == '0) begin
                        err_code   <= ERR_TIMEOUT;
                        num_err    <= 1'b1;
                        char_ready <= 1'b0;
                        state      <= ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                OUT, ERR: begin
                    w_hund     <= 4'd0;
                    w_tens     <= 4'd0;
                    w_units    <= 4'd0;
                    digit_cnt  <= 2'd0;
                    tmo_cnt    <= '0;
                    char_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    char_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ascii2bcd.md
ASCII2BCD -- requirements
Module: ascii2bcd

Interface
REQ-001 SHALL have parameter TERM_CHAR, default 8'h0D, the terminator character that commits a number.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, the maximum idle cycles allowed between characters inside a number.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port char_in, input, 8 bits: ASCII character, sampled when char_valid is high and char_ready is high.
REQ-007 SHALL have port char_valid, input, 1 bit: one-cycle strobe marking char_in valid.
REQ-008 SHALL have port char_ready, output, 1 bit: high when a character can be accepted.
REQ-009 SHALL have ports bcd_0, bcd_1, bcd_2, output, 4 bits each: units, tens and hundreds of the last committed number.
REQ-010 SHALL have port bin_out, output, 10 bits: unsigned binary value of the last committed number.
REQ-011 SHALL have port num_valid, output, 1 bit: one-cycle pulse on commit.
REQ-012 SHALL have port num_err, output, 1 bit: one-cycle pulse on abort.
REQ-013 SHALL have port err_code, output, 2 bits: 0 none, 1 bad character, 2 overflow, 3 timeout.
REQ-014 SHALL have port digit_cnt, output, 2 bits: digits held in the working register (0-3).

Function
REQ-015 SHALL use FSM states IDLE, DIG, OUT and ERR.
REQ-016 SHALL treat a character as accepted only when char_valid is high and char_ready is high; a char_valid while char_ready is low is dropped silently.
REQ-017 SHALL drive char_ready high in IDLE and DIG, and low in OUT and ERR.
REQ-018 In IDLE, SHALL handle accepted characters as follows:
- digit 8'h30-8'h39: load the working units digit with char-8'h30, set digit_cnt to 1, go to DIG.
- TERM_CHAR or space 8'h20: ignore, stay in IDLE.
- any other character: go to ERR with code 1.
REQ-019 In DIG, SHALL handle accepted characters as follows:
- digit with digit_cnt<3: shift the working digits (hundreds<=tens, tens<=units, units<=new), then increment digit_cnt.
- digit with digit_cnt==3: go to ERR with code 2.
- TERM_CHAR: go to OUT.
- any other character: go to ERR with code 1.
REQ-020 In DIG, SHALL hold a timeout counter that clears on every accepted character; on reaching TIMEOUT_CYCLES-1 without a character, SHALL go to ERR with code 3.
REQ-021 On the edge accepting TERM_CHAR, SHALL register bcd_2/1/0 from the working digits and bin_out = hundreds*100 + tens*10 + units (unsigned, zero-extended, maximum 999).
REQ-022 SHALL assert num_valid for exactly the single OUT cycle, with outputs already updated (latency: 1 cycle after the TERM_CHAR acceptance).
REQ-023 SHALL treat missing high digits as zero (e.g. "42" gives bcd_2=0, bcd_1=4, bcd_0=2) and keep leading zeros (e.g. "007" gives bin_out=7).
REQ-024 In ERR, SHALL assert num_err for exactly one cycle, update err_code on entry and hold it until the next error or reset, and leave bcd_* and bin_out unchanged.
REQ-025 SHALL go from OUT and from ERR to IDLE unconditionally after one cycle, clearing the working digits, digit_cnt and the timeout counter.
REQ-026 SHALL hold bcd_* and bin_out stable between commits.
REQ-027 SHALL keep the timeout counter cleared in IDLE (no timeout in IDLE).

Reset
REQ-028 While rst is high at a clock edge, SHALL set state=IDLE; working digits, digit_cnt, timeout counter, bcd_*, bin_out and err_code to 0; num_valid and num_err to 0; char_ready to 1.
REQ-029 SHALL let reset asserted mid-number (in DIG, OUT or ERR) abort without a num_valid or num_err pulse.

Structure
REQ-030 SHALL take the FSM state enum, ASCII constants (8'h30, 8'h39, 8'h20, 8'h0D) and err_code values from shared package ascii_pkg.
REQ-031 SHALL place the BCD-to-binary conversion in combinational sub-module bcd3_to_bin (three 4-bit digits in, 10-bit value out), shift-add only, no multiplier.

Verification
REQ-032 SHALL verify: "1","2","3",0x0D -> one cycle later num_valid=1, bcd_2/1/0=1/2/3, bin_out=123, err_code=0.
REQ-033 SHALL verify: "9","9","9","9" -> num_err=1, err_code=2, bcd_*/bin_out keep their prior values.
REQ-034 SHALL verify: "4","A" -> num_err=1, err_code=1; then "7",0x0D -> bin_out=7, bcd=0/0/7.
REQ-035 SHALL verify: TIMEOUT_CYCLES=16, "5" then no character for 16 cycles -> num_err=1, err_code=3, state IDLE.
REQ-036 SHALL verify: char_valid in the OUT cycle is dropped; rst during DIG after "8" -> all outputs 0, no pulse, char_ready=1.
